// File: rtl/mac_block_accumulator_if.sv
// Stream bundle for the block accumulator: sample input side and
// single-entry result output side, both valid/ready.
interface mac_block_accumulator_if #(
    parameter int OUT_WIDTH = 16,
    parameter int BLOCK_LEN = 4,
    parameter int ACC_WIDTH = 18,
    parameter int CNT_WIDTH = $clog2(BLOCK_LEN + 1)
);
    logic [OUT_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic [ACC_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_sat;
    logic                 out_valid;
    logic                 out_ready;

    // Producer/consumer side (drives samples, flush and result ready).
    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_count, out_sat, out_valid
    );

    // Accumulator side.
    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_count, out_sat, out_valid
    );
endinterface

// File: rtl/mac_block_accumulator.sv
// Block accumulator: sums BLOCK_LEN accepted samples (or a flushed partial
// block) into a saturating ACC_WIDTH-bit result held in a one-entry output
// register. Input stalls only when the completing sample has no free slot.
module mac_block_accumulator #(
    parameter int OUT_WIDTH = 16,
    parameter int BLOCK_LEN = 4,
    parameter int ACC_WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mac_block_accumulator_if.slave   bus
);
    localparam int CNT_WIDTH = $clog2(BLOCK_LEN + 1);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BLOCK_LEN - 1);

    // STALL means the block is one sample short of complete and the
    // output register is occupied; it is the only state that blocks input.
    typedef enum logic [1:0] {IDLE, ACCUM, STALL} state_t;

    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] acc, acc_nxt, sum_sat;
    logic [ACC_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
    logic                 sat, sat_nxt, sat_inc;
    logic [ACC_WIDTH-1:0] od_nxt;
    logic [CNT_WIDTH-1:0] oc_nxt;
    logic                 os_nxt, ov_nxt;
    logic                 slot_free, accept, complete, do_flush, load;

    assign slot_free    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state != STALL) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // One extra bit catches overflow; clamp to all-ones and mark the block.
    assign sum     = {1'b0, acc} + (ACC_WIDTH + 1)'(bus.in_data);
    assign sum_sat = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
    assign sat_inc = sat | sum[ACC_WIDTH];
    assign cnt_inc = cnt + CNT_WIDTH'(1);

    // Completion wins over flush; flush needs something to emit.
    assign complete = accept && (cnt == LAST);
    assign do_flush = bus.flush && slot_free && (cnt != '0 || accept) && !complete;
    assign load     = (complete && slot_free) || do_flush;

    // Next-state and next-register values; defaults hold everything.
    always_comb begin
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sat_nxt   = sat;
        od_nxt    = bus.out_data;
        oc_nxt    = bus.out_count;
        os_nxt    = bus.out_sat;
        ov_nxt    = bus.out_valid;
        state_nxt = state;
        if (load) begin
            od_nxt  = accept ? sum_sat : acc;
            oc_nxt  = accept ? cnt_inc : cnt;
            os_nxt  = accept ? sat_inc : sat;
            ov_nxt  = 1'b1;
            acc_nxt = '0;
            cnt_nxt = '0;
            sat_nxt = 1'b0;
        end else begin
            if (bus.out_ready)
                ov_nxt = 1'b0;
            if (accept) begin
                acc_nxt = sum_sat;
                cnt_nxt = cnt_inc;
                sat_nxt = sat_inc;
            end
        end
        if (cnt_nxt == '0)
            state_nxt = IDLE;
        else if (cnt_nxt == LAST && ov_nxt)
            state_nxt = STALL;
        else
            state_nxt = ACCUM;
    end

    // State, accumulator and output register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            sat           <= 1'b0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            state         <= state_nxt;
            acc           <= acc_nxt;
            cnt           <= cnt_nxt;
            sat           <= sat_nxt;
            bus.out_data  <= od_nxt;
            bus.out_count <= oc_nxt;
            bus.out_sat   <= os_nxt;
            bus.out_valid <= ov_nxt;
        end
    end
endmodule
